// File: rtl/rr_onehot_sel_arbiter.sv
// Round-robin arbiter driving a one-hot mux select with a sticky, registered grant.
// Optional ARB_BURST_EN lets one requester keep the grant for up to BURST_LEN transfers.
module rr_onehot_sel_arbiter #(
  parameter int N_REQ     = 6,
  parameter int IDX_W     = 3,
  parameter int BURST_LEN = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             sel_ready,
  output logic [N_REQ-1:0] sel,
  output logic             sel_valid,
  output logic [IDX_W-1:0] grant_idx
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [IDX_W-1:0] PTR_RST = IDX_W'(N_REQ - 1);
  localparam logic [N_REQ-1:0] ONE     = N_REQ'(1);

  state_t           state;
  state_t           state_n;
  logic [N_REQ-1:0] sel_n;
  logic             valid_n;
  logic [IDX_W-1:0] idx_n;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] ptr_n;
  logic             any_req;
  logic             xfer;

  // First requester strictly after p, wrapping; p itself comes last.
  function automatic logic [IDX_W-1:0] rr_pick(
    input logic [N_REQ-1:0] r,
    input logic [IDX_W-1:0] p
  );
    logic [IDX_W-1:0] pick;
    logic             hit;
    int               j;
    pick = '0;
    hit  = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      j = (int'(p) + k) % N_REQ;
      if (!hit && r[j]) begin
        hit  = 1'b1;
        pick = IDX_W'(j);
      end
    end
    return pick;
  endfunction

  assign any_req = |req;
  assign xfer    = sel_valid && sel_ready;

`ifdef ARB_BURST_EN
  localparam int CNT_W = $clog2(BURST_LEN + 1);

  logic [CNT_W-1:0] burst_cnt;
  logic [CNT_W-1:0] burst_n;
  logic             stay;

  assign stay = req[grant_idx] && ((int'(burst_cnt) + 1) < BURST_LEN);
`endif

  always_comb begin
    state_n = state;
    sel_n   = sel;
    valid_n = sel_valid;
    idx_n   = grant_idx;
    ptr_n   = ptr;
`ifdef ARB_BURST_EN
    burst_n = burst_cnt;
`endif
    unique case (state)
      IDLE: begin
`ifdef ARB_BURST_EN
        burst_n = '0;
`endif
        if (any_req) begin
          idx_n   = rr_pick(req, ptr);
          sel_n   = ONE << idx_n;
          valid_n = 1'b1;
          state_n = GRANT;
        end else begin
          sel_n   = '0;
          valid_n = 1'b0;
          idx_n   = '0;
        end
      end
      GRANT: begin
        if (xfer) begin
`ifdef ARB_BURST_EN
          if (stay) begin
            burst_n = burst_cnt + CNT_W'(1);
          end else
`endif
          if (any_req) begin
            ptr_n = grant_idx;
            idx_n = rr_pick(req, grant_idx);
            sel_n = ONE << idx_n;
`ifdef ARB_BURST_EN
            burst_n = '0;
`endif
          end else begin
            ptr_n   = grant_idx;
            sel_n   = '0;
            valid_n = 1'b0;
            idx_n   = '0;
            state_n = IDLE;
`ifdef ARB_BURST_EN
            burst_n = '0;
`endif
          end
        end
      end
      default: begin
        state_n = IDLE;
        sel_n   = '0;
        valid_n = 1'b0;
        idx_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sel       <= '0;
      sel_valid <= 1'b0;
      grant_idx <= '0;
      ptr       <= PTR_RST;
`ifdef ARB_BURST_EN
      burst_cnt <= '0;
`endif
    end else begin
      state     <= state_n;
      sel       <= sel_n;
      sel_valid <= valid_n;
      grant_idx <= idx_n;
      ptr       <= ptr_n;
`ifdef ARB_BURST_EN
      burst_cnt <= burst_n;
`endif
    end
  end

endmodule

// File: tb/tb_rr_onehot_sel_arbiter.sv
// Scoreboard bench for rr_onehot_sel_arbiter.
// Expected grants are queued with each stimulus cycle and compared one cycle later.
module tb_rr_onehot_sel_arbiter;

  localparam int N_REQ = 6;
  localparam int IDX_W = 3;

  typedef struct {
    logic             valid;
    logic [IDX_W-1:0] idx;
    logic [N_REQ-1:0] sel;
    string            tag;
  } exp_t;

  logic             clk;
  logic             rst;
  logic [N_REQ-1:0] req;
  logic             sel_ready;
  logic [N_REQ-1:0] sel;
  logic             sel_valid;
  logic [IDX_W-1:0] grant_idx;

  int   checks;
  int   errors;
  exp_t sb[$];

  rr_onehot_sel_arbiter #(
    .N_REQ(N_REQ),
    .IDX_W(IDX_W),
    .BURST_LEN(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .sel_ready(sel_ready),
    .sel(sel),
    .sel_valid(sel_valid),
    .grant_idx(grant_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, queue what the registered outputs must show after the edge.
  task automatic step(
    input string            tag,
    input logic             r,
    input logic [N_REQ-1:0] rq,
    input logic             rdy,
    input logic             ev,
    input int               ei
  );
    exp_t e;
    exp_t o;
    logic [N_REQ-1:0] one;
    one     = N_REQ'(1);
    rst       = r;
    req       = rq;
    sel_ready = rdy;
    e.tag   = tag;
    e.valid = ev;
    e.idx   = ev ? IDX_W'(ei) : '0;
    e.sel   = ev ? (one << ei) : '0;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      o = sb.pop_front();
      check({o.tag, "_valid"}, 32'(sel_valid), 32'(o.valid));
      check({o.tag, "_idx"}, 32'(grant_idx), 32'(o.idx));
      check({o.tag, "_sel"}, 32'(sel), 32'(o.sel));
      check({o.tag, "_inv"},
            32'(sel_valid ? $onehot(sel) : (sel == '0)), 32'd1);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      inv_a: assert (sel_valid ? $onehot(sel) : (sel == '0))
        else $error("select invariant broken: sel=%b valid=%b", sel, sel_valid);
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    req       = '0;
    sel_ready = 1'b0;
    #2;

    step("rst0", 1'b1, 6'b000000, 1'b0, 1'b0, 0);
    step("rst1", 1'b1, 6'b000000, 1'b0, 1'b0, 0);
    for (int i = 0; i < 5; i++)
      step("idle", 1'b0, 6'b000000, 1'b1, 1'b0, 0);
    step("t1_grant", 1'b0, 6'b000100, 1'b0, 1'b1, 2);
    step("t1_drain", 1'b0, 6'b000000, 1'b1, 1'b0, 0);

`ifndef ARB_BURST_EN
    step("t2_rst", 1'b1, 6'b000000, 1'b0, 1'b0, 0);
    begin
      int seq[8] = '{0, 1, 2, 3, 4, 5, 0, 1};
      foreach (seq[i])
        step("t2_rr", 1'b0, 6'b111111, 1'b1, 1'b1, seq[i]);
    end
    step("t2_drain", 1'b0, 6'b000000, 1'b1, 1'b0, 0);
`endif

    step("t3_grant", 1'b0, 6'b001000, 1'b0, 1'b1, 3);
    for (int i = 0; i < 4; i++)
      step("t3_hold", 1'b0, 6'b100000, 1'b0, 1'b1, 3);
    step("t3_next", 1'b0, 6'b100000, 1'b1, 1'b1, 5);
    step("t3_drain", 1'b0, 6'b000000, 1'b1, 1'b0, 0);

    step("t4_first", 1'b0, 6'b000001, 1'b1, 1'b1, 0);
    for (int i = 0; i < 3; i++)
      step("t4_again", 1'b0, 6'b000001, 1'b1, 1'b1, 0);
    step("t4_drain", 1'b0, 6'b000000, 1'b1, 1'b0, 0);
    step("t4_idle", 1'b0, 6'b000000, 1'b1, 1'b0, 0);

`ifdef ARB_BURST_EN
    step("t5_rst", 1'b1, 6'b000000, 1'b0, 1'b0, 0);
    begin
      int bseq[9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
      foreach (bseq[i])
        step("t5_burst", 1'b0, 6'b000011, 1'b1, 1'b1, bseq[i]);
    end
    step("t5_drain", 1'b0, 6'b000000, 1'b1, 1'b0, 0);
`endif

    step("t6_grant", 1'b0, 6'b010000, 1'b0, 1'b1, 4);
    step("t6_hold", 1'b0, 6'b010000, 1'b0, 1'b1, 4);
    step("t6_rst", 1'b1, 6'b111111, 1'b0, 1'b0, 0);
    step("t6_first", 1'b0, 6'b111111, 1'b0, 1'b1, 0);
`ifndef ARB_BURST_EN
    step("t6_second", 1'b0, 6'b111111, 1'b1, 1'b1, 1);
`else
    step("t6_second", 1'b0, 6'b111111, 1'b1, 1'b1, 0);
`endif
    step("t6_drain", 1'b0, 6'b000000, 1'b1, 1'b0, 0);

    check("sb_left", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_onehot_sel_arbiter.md
Name: rr_onehot_sel_arbiter

Overview:
Round-robin arbiter that sits directly upstream of the 6-input, 4-bit one-hot multiplexer and drives its 6-bit one-hot select. It accepts per-source request lines and issues a registered, stable, one-hot grant. The grant is held until the downstream consumer accepts the muxed data. Outside a valid grant, the select is all-zero, so the mux output is 4'b0000.

Parameters:
N_REQ, 6, number of requesters; equals the mux select width.
IDX_W, 3, width of the binary grant index; must satisfy 2**IDX_W >= N_REQ.
BURST_LEN, 4, maximum consecutive grants to one requester; used only when ARB_BURST_EN is defined.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous active-high reset.
req  input  N_REQ  per-source request; bit i corresponds to mux input_i.
sel_ready  input  1  downstream accepts the current muxed word this cycle.
sel  output  N_REQ  registered one-hot grant to the mux select; all-zero when not valid.
sel_valid  output  1  sel holds a live grant.
grant_idx  output  IDX_W  binary index of the set bit of sel; 0 when not valid.

Behaviour:
- All outputs are registered. No combinational path exists from req or sel_ready to any output.
- Reset, synchronous and sampled on the clk edge with rst=1:
  - sel=0, sel_valid=0, grant_idx=0, state=IDLE.
  - Priority pointer ptr=N_REQ-1, so the first search starts at index 0.
  - With ARB_BURST_EN, burst_cnt=0.
  - Reset asserted mid-grant drops the grant at that edge and discards any pending transfer.
- Search function: the first set bit of req scanning ptr+1, ptr+2, ..., wrapping modulo N_REQ, ending at ptr. The search can select ptr itself only if ptr is the sole requester.
- State IDLE:
  - If req != 0, load sel with the search result, set sel_valid=1 and grant_idx, and go to GRANT.
  - Latency: req rising in cycle t gives sel_valid=1 in cycle t+1.
  - If req == 0, stay in IDLE with sel=0.
- State GRANT:
  - sel_valid=1 and sel_ready=0: sel and grant_idx hold unchanged. The grant is sticky; a requester dropping req does not revoke it.
  - sel_valid=1 and sel_ready=1 (transfer): ptr becomes grant_idx.
    - If req is nonzero this cycle, load the next grant from a search that uses the updated ptr and stay in GRANT. Back-to-back transfers are supported with no bubble.
    - Otherwise clear sel and grant_idx, set sel_valid=0, and go to IDLE.
- sel_ready while sel_valid=0 is ignored.
- Invariant: $onehot(sel) when sel_valid=1, and sel==0 when sel_valid=0. This invariant is checked by assertion in the bench.
- Bits of req above N_REQ do not exist; widths are derived from N_REQ only.
- Fairness: with all requests held high and sel_ready=1, grant order is 0,1,2,3,4,5,0,...

Optional Feature:
Macro ARB_BURST_EN.
- Defined:
  - A burst counter of width clog2(BURST_LEN+1) is added.
  - On a transfer, if req[grant_idx] is still 1 and burst_cnt+1 < BURST_LEN, the same requester is re-granted, burst_cnt increments, and ptr is not updated.
  - Otherwise normal round-robin applies, with ptr=grant_idx, and burst_cnt returns to 0 on the new grant.
  - burst_cnt is also cleared on entry to IDLE.
- Not defined: no counter exists, and every transfer advances round-robin as described in Behaviour.

Test Plan:
1. Reset release with req=0 for 5 cycles -> sel=0, sel_valid=0, grant_idx=0 throughout. Then assert req=6'b000100 -> next cycle sel=6'b000100, grant_idx=2.
2. req=6'b111111 held, sel_ready=1 constant -> grant_idx sequence 0,1,2,3,4,5,0,1 on consecutive cycles with no bubbles (without ARB_BURST_EN).
3. Backpressure: grant on index 3, sel_ready=0 for 4 cycles while req[3] drops and req[5] rises -> sel stays 6'b001000. Then sel_ready=1 -> next cycle sel=6'b100000.
4. Single requester req=6'b000001, sel_ready=1 -> sel=6'b000001 re-granted every cycle. Then req=0 -> after the final transfer, sel=0 and sel_valid=0 on the following cycle.
5. With ARB_BURST_EN and BURST_LEN=4: req=6'b000011, sel_ready=1 -> grant_idx 0,0,0,0,1,1,1,1,0.
6. rst=1 pulsed for one cycle while sel=6'b010000 and sel_ready=0 -> sel=0 and sel_valid=0 the next cycle. With all requests asserted afterwards, the first grant is index 0.
